// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per cycle, LSB first, through a
// single full subtractor and a borrow flip-flop.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             dbit;
  logic             bnext;

  full_subtractor u_fs (
    .a    (areg[0]),
    .b    (breg[0]),
    .bin  (br),
    .diff (dbit),
    .bout (bnext)
  );

  // Outputs are registered: done, diff and bout are loaded on the edge that
  // leaves DONE, so the pulse shows up one cycle after the DONE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          areg <= areg >> 1;
          breg <= breg >> 1;
          res  <= {dbit, res[WIDTH-1:1]};
          br   <= bnext;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
          diff <= res;
          bout <= br;
          if (start) begin
            areg  <= a;
            breg  <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] diff4;
  logic       bout4, busy4, done4;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] diff8;
  logic       bout8, busy8, done8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation on the chosen DUT; lat counts negedges from the start
  // request to the done pulse, pulseOk reports that done dropped again.
  task automatic applyStimulus(input int w, input logic [7:0] av, input logic [7:0] bv,
                               input logic bi, output logic [7:0] gd, output logic gb,
                               output int lat, output logic pulseOk);
    logic seen;
    seen = 1'b0;
    lat = 0;
    gd = '0;
    gb = 1'b0;
    @(negedge clk);
    if (w == 4) begin
      a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi; start4 = 1'b1;
    end else begin
      a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    end
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start4 = 1'b0;
        start8 = 1'b0;
      end
      if ((w == 4) ? done4 : done8) begin
        seen = 1'b1;
        lat = n;
        gd = (w == 4) ? {4'h0, diff4} : diff8;
        gb = (w == 4) ? bout4 : bout8;
      end
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    pulseOk = (w == 4) ? !done4 : !done8;
  endtask

  initial begin
    logic [7:0] gd;
    logic       gb;
    logic       pok;
    int         lat;
    int         ndone, t1, t2;
    logic [3:0] d1, d2;
    logic       bo1, bo2;

    vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd0,  4'd1,  1'b0, 4'd15, 1'b1};
    vecs[5] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
    vecs[6] = '{4'd8,  4'd8,  1'b1, 4'd15, 1'b1};
    vecs[7] = '{4'd10, 4'd4,  1'b1, 4'd5,  1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset_diff4", {28'd0, diff4}, 32'd0);
    checkOutput("reset_flags4", {29'd0, bout4, busy4, done4}, 32'd0);
    checkOutput("reset_out8", {21'd0, diff8, bout8, busy8, done8}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(4, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, vecs[i].bin, gd, gb, lat, pok);
      checkOutput($sformatf("vec%0d_diff", i), {24'd0, gd}, {28'd0, vecs[i].diff});
      checkOutput($sformatf("vec%0d_bout", i), {31'd0, gb}, {31'd0, vecs[i].bout});
      checkOutput($sformatf("vec%0d_latency", i), lat, 32'd6);
      checkOutput($sformatf("vec%0d_pulse", i), {31'd0, pok}, 32'd1);
    end
    repeat (3) @(negedge clk);
    checkOutput("hold_diff", {28'd0, diff4}, 32'd5);
    checkOutput("hold_bout", {31'd0, bout4}, 32'd0);

    // Operands and start changing mid-operation must not disturb the result.
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    ndone = 0; d1 = '0; bo1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) checkOutput("busy_high", {31'd0, busy4}, 32'd1);
      if (n == 1) a4 = 4'd1;
      if (n == 2) begin a4 = ~a4; b4 = ~b4; end
      if (n == 3) start4 = 1'b0;
      if (done4) begin
        ndone++;
        d1 = diff4;
        bo1 = bout4;
      end
    end
    checkOutput("ignore_done_count", ndone, 32'd1);
    checkOutput("ignore_diff", {28'd0, d1}, 32'd5);
    checkOutput("ignore_bout", {31'd0, bo1}, 32'd0);

    // Back-to-back: start held through DONE picks up the second operand pair.
    @(negedge clk);
    a4 = 4'd4; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
    ndone = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0; bo1 = 1'b0; bo2 = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n == 1) begin a4 = 4'd2; b4 = 4'd3; end
      if (n == 6) start4 = 1'b0;
      if (done4) begin
        ndone++;
        if (ndone == 1) begin t1 = n; d1 = diff4; bo1 = bout4; end
        else begin t2 = n; d2 = diff4; bo2 = bout4; end
      end
    end
    checkOutput("b2b_done_count", ndone, 32'd2);
    checkOutput("b2b_first_latency", t1, 32'd6);
    checkOutput("b2b_gap", t2 - t1, 32'd5);
    checkOutput("b2b_diff1", {28'd0, d1}, 32'd3);
    checkOutput("b2b_bout1", {31'd0, bo1}, 32'd0);
    checkOutput("b2b_diff2", {28'd0, d2}, 32'd15);
    checkOutput("b2b_bout2", {31'd0, bo2}, 32'd1);

    // Reset during the second SHIFT cycle abandons the operation.
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd0; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_diff", {28'd0, diff4}, 32'd0);
    checkOutput("midreset_flags", {29'd0, bout4, busy4, done4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    checkOutput("midreset_no_done", ndone, 32'd0);
    applyStimulus(4, 8'd8, 8'd8, 1'b0, gd, gb, lat, pok);
    checkOutput("after_reset_diff", {24'd0, gd}, 32'd0);
    checkOutput("after_reset_bout", {31'd0, gb}, 32'd0);
    checkOutput("after_reset_latency", lat, 32'd6);

    for (int w = 4; w <= 8; w += 4) begin
      for (int i = 0; i < 1000; i++) begin
        logic [7:0] av, bv;
        logic       bi;
        int         x;
        av = 8'($urandom_range(0, (1 << w) - 1));
        bv = 8'($urandom_range(0, (1 << w) - 1));
        bi = 1'($urandom_range(0, 1));
        x = int'(av) - int'(bv) - int'(bi);
        applyStimulus(w, av, bv, bi, gd, gb, lat, pok);
        checkOutput($sformatf("rnd%0d_diff", w), {24'd0, gd}, x & ((1 << w) - 1));
        checkOutput($sformatf("rnd%0d_bout", w), {31'd0, gb}, (x < 0) ? 32'd1 : 32'd0);
        checkOutput($sformatf("rnd%0d_latency", w), lat, w + 2);
        checkOutput($sformatf("rnd%0d_pulse", w), {31'd0, pok}, 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request; sampled only while busy=0.
REQ-005 Port: a  input  WIDTH  minuend; unsigned; sampled with start.
REQ-006 Port: b  input  WIDTH  subtrahend; unsigned; sampled with start.
REQ-007 Port: bin  input  1  borrow-in; sampled with start.
REQ-008 Port: diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
REQ-009 Port: bout  output  1  borrow-out; 1 iff a < b + bin.
REQ-010 Port: busy  output  1  high while an operation is in progress.
REQ-011 Port: done  output  1  single-cycle pulse when diff and bout become valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: busy=0; if start=1, the block SHALL capture a, b and bin into internal registers, clear the bit counter, and go to SHIFT.
REQ-014 SHIFT: busy=1; each cycle one bit pair SHALL be processed, LSB first.
REQ-015 In SHIFT, the difference bit SHALL shift into the result register from the MSB end; the borrow register SHALL update; the counter SHALL increment.
REQ-016 Borrow register init = captured bin; per bit: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~ai & br) | (bi & br).
REQ-017 After exactly WIDTH SHIFT cycles the FSM SHALL go to DONE; the counter SHALL not wrap.
REQ-018 DONE: busy=0, done=1 for one cycle; diff = result register; bout = final borrow.
REQ-019 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH+1.
REQ-020 diff and bout SHALL hold their values from DONE until the next DONE, or until reset.
REQ-021 start while busy=1 SHALL be ignored; a, b and bin changes during SHIFT SHALL have no effect.
REQ-022 start=1 in DONE SHALL be accepted (back-to-back): capture operands and go to SHIFT; done still pulses that cycle.
REQ-023 DONE with start=0 SHALL go to IDLE.
REQ-024 done SHALL never be high in two consecutive cycles.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH; no overflow flag is produced.

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, diff=0, bout=0, busy=0, done=0, counter=0, borrow register=0, operand registers=0.
REQ-027 Reset mid-SHIFT SHALL abandon the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-028 FSM state encodings and the default WIDTH SHALL reside in the shared package serial_arith_pkg.
REQ-029 The per-bit logic SHALL be one sub-module, full_subtractor (ports a, b, bin, diff, bout), instantiated once.
REQ-030 The datapath SHALL be two shift registers plus one borrow flip-flop; no WIDTH-bit subtractor SHALL be inferred.

Verification
REQ-031 WIDTH=4: a=9, b=3, bin=0, start -> done at cycle 6 after start edge; diff=6, bout=0.
REQ-032 a=3, b=5, bin=0 -> diff=14, bout=1; a=0, b=0, bin=1 -> diff=15, bout=1; a=15, b=15, bin=0 -> diff=0, bout=0.
REQ-033 Start a=7, b=2, then start with a=1 and toggle a/b during SHIFT -> single done, diff=5, bout=0.
REQ-034 Back-to-back: start held through DONE with a=4, b=1 then a=2, b=3 -> two done pulses WIDTH+1 cycles apart; diff=3/bout=0, then diff=15/bout=1.
REQ-035 rst_n pulsed low in the 2nd SHIFT cycle -> all outputs 0 at once and no done; next start a=8, b=8 -> diff=0, bout=0.
REQ-036 Randomized: 1000 operands, WIDTH=4 and WIDTH=8, checked against a reference model of (a - b - bin); done pulse width always 1 cycle.
